// File: rtl/proc_run_harness_if.sv
// Run-control bundle between a test driver and proc_run_harness.
// Driver side (master) issues start/abort/core status; harness (slave) reports run state.
interface proc_run_harness_if #(
  parameter int N_CORES = 1,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               abort;
  logic [N_CORES-1:0] core_done;
  logic [N_CORES-1:0] core_ok;
  logic [N_CORES-1:0] core_reset;
  logic               busy;
  logic               finished;
  logic               pass;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_count;
  logic [N_CORES-1:0] done_mask;
  logic [N_CORES-1:0] fail_mask;

  modport master (
    output start, abort, core_done, core_ok,
    input  core_reset, busy, finished, pass, timeout,
    input  cycle_count, done_mask, fail_mask
  );

  modport slave (
    input  start, abort, core_done, core_ok,
    output core_reset, busy, finished, pass, timeout,
    output cycle_count, done_mask, fail_mask
  );
endinterface

// File: rtl/proc_run_harness.sv
// Run controller: holds cores in reset, runs them, collects done/ok, reports pass/fail/timeout.
// Ports: clock, reset (async active-low), bus (slave side of proc_run_harness_if).
module proc_run_harness #(
  parameter int N_CORES        = 1,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = 16
) (
  input logic                clock,
  input logic                reset,
  proc_run_harness_if.slave  bus
);
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_END
  } state_t;

  state_t             state;
  logic [HW-1:0]      hold;
  logic               rst_core;
  logic               busy;
  logic               finished;
  logic               pass;
  logic               timeout;
  logic [CNT_W-1:0]   cycle_count;
  logic [N_CORES-1:0] done_mask;
  logic [N_CORES-1:0] fail_mask;

  logic [N_CORES-1:0] nxt_done;
  logic [N_CORES-1:0] nxt_fail;
  logic               all_done;
  logic               at_limit;

  // Only the first sighting of a core's done captures its ok bit.
  always_comb begin
    nxt_done = done_mask | bus.core_done;
    nxt_fail = fail_mask |
               (bus.core_done & ~done_mask & ~bus.core_ok);
    all_done = &nxt_done;
    at_limit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      hold        <= '0;
      rst_core    <= 1'b1;
      busy        <= 1'b0;
      finished    <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      done_mask   <= '0;
      fail_mask   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_END: begin
          if (bus.start) begin
            state       <= S_HOLD;
            hold        <= HW'(RESET_CYCLES - 1);
            rst_core    <= 1'b1;
            busy        <= 1'b1;
            finished    <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            done_mask   <= '0;
            fail_mask   <= '0;
          end
        end
        S_HOLD: begin
          if (bus.abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            rst_core <= 1'b1;
          end else if (hold == '0) begin
            state    <= S_RUN;
            rst_core <= 1'b0;
          end else begin
            hold <= hold - 1'b1;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            rst_core    <= 1'b1;
            cycle_count <= '0;
            done_mask   <= '0;
            fail_mask   <= '0;
          end else begin
            done_mask <= nxt_done;
            fail_mask <= nxt_fail;
            // Completion beats timeout when both land together.
            if (all_done || at_limit) begin
              state    <= S_END;
              busy     <= 1'b0;
              finished <= 1'b1;
              rst_core <= 1'b1;
              pass     <= all_done && (nxt_fail == '0);
              timeout  <= !all_done;
            end else if (cycle_count != '1) begin
              cycle_count <= cycle_count + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.core_reset  = {N_CORES{rst_core}};
  assign bus.busy        = busy;
  assign bus.finished    = finished;
  assign bus.pass        = pass;
  assign bus.timeout     = timeout;
  assign bus.cycle_count = cycle_count;
  assign bus.done_mask   = done_mask;
  assign bus.fail_mask   = fail_mask;
endmodule

// File: tb/tb_proc_run_harness.sv
// Directed bench for proc_run_harness with two cores.
// Drives the run-control interface and checks each step with immediate assertions.
module tb_proc_run_harness;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  proc_run_harness_if #(.N_CORES(2), .CNT_W(16)) bus ();

  proc_run_harness #(
    .N_CORES(2),
    .RESET_CYCLES(2),
    .TIMEOUT_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_end(input string tag, input logic ps,
                         input logic to, input int cnt,
                         input logic [1:0] dm, input logic [1:0] fm);
    check({tag, "_fin"},  32'(bus.finished), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'(ps));
    check({tag, "_to"},   32'(bus.timeout), 32'(to));
    check({tag, "_cnt"},  32'(bus.cycle_count), 32'(cnt));
    check({tag, "_dm"},   32'(bus.done_mask), 32'(dm));
    check({tag, "_fm"},   32'(bus.fail_mask), 32'(fm));
    check({tag, "_crst"}, 32'(bus.core_reset), 32'h3);
  endtask

  // start pulse, two HOLD cycles, returns in RUN cycle 0
  task automatic start_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.core_done = 2'b00;
    bus.core_ok   = 2'b00;
    #12;
    check("rst_crst", 32'(bus.core_reset), 32'h3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fin",  32'(bus.finished), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_crst", 32'(bus.core_reset), 32'h3);

    // nominal run
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("nom_busy", 32'(bus.busy), 32'd1);
    check("nom_h0",   32'(bus.core_reset), 32'h3);
    tick();
    check("nom_h1",   32'(bus.core_reset), 32'h3);
    tick();
    check("nom_r0",   32'(bus.core_reset), 32'h0);
    check("nom_c0",   32'(bus.cycle_count), 32'd0);
    tick();
    tick();
    tick();
    check("nom_c3",   32'(bus.cycle_count), 32'd3);
    bus.core_done = 2'b11;
    bus.core_ok   = 2'b11;
    tick();
    bus.core_done = 2'b00;
    chk_end("nom", 1'b1, 1'b0, 3, 2'b11, 2'b00);

    // staggered done with failure on core1
    start_run();
    tick();
    bus.core_done = 2'b01;
    bus.core_ok   = 2'b01;
    tick();
    tick();
    bus.core_ok   = 2'b00;
    check("stg_dm", 32'(bus.done_mask), 32'h1);
    check("stg_fm", 32'(bus.fail_mask), 32'h0);
    tick();
    bus.core_done = 2'b00;
    tick();
    check("stg_c5", 32'(bus.cycle_count), 32'd5);
    check("stg_nf", 32'(bus.finished), 32'd0);
    bus.core_done = 2'b10;
    tick();
    bus.core_done = 2'b00;
    chk_end("stg", 1'b0, 1'b0, 5, 2'b11, 2'b10);

    // timeout with only core0 done
    start_run();
    bus.core_done = 2'b01;
    bus.core_ok   = 2'b01;
    repeat (7) tick();
    check("to_c7", 32'(bus.cycle_count), 32'd7);
    check("to_nf", 32'(bus.finished), 32'd0);
    tick();
    bus.core_done = 2'b00;
    chk_end("to", 1'b0, 1'b1, 7, 2'b01, 2'b00);

    // abort ignored in END
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("endab_fin", 32'(bus.finished), 32'd1);

    // restart from END clears status
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("rs_busy", 32'(bus.busy), 32'd1);
    check("rs_fin",  32'(bus.finished), 32'd0);
    check("rs_to",   32'(bus.timeout), 32'd0);
    check("rs_dm",   32'(bus.done_mask), 32'h0);
    check("rs_crst", 32'(bus.core_reset), 32'h3);
    tick();
    check("rs_h1",   32'(bus.core_reset), 32'h3);
    tick();
    check("rs_run",  32'(bus.core_reset), 32'h0);

    // simultaneous completion and timeout
    bus.core_done = 2'b01;
    bus.core_ok   = 2'b11;
    repeat (7) tick();
    bus.core_done = 2'b10;
    tick();
    bus.core_done = 2'b00;
    chk_end("sim", 1'b1, 1'b0, 7, 2'b11, 2'b00);

    // done held through HOLD is ignored, then abort mid-run
    bus.start     = 1'b1;
    bus.core_done = 2'b11;
    bus.core_ok   = 2'b00;
    tick();
    bus.start     = 1'b0;
    tick();
    bus.core_done = 2'b00;
    tick();
    check("hld_dm", 32'(bus.done_mask), 32'h0);
    check("hld_nf", 32'(bus.finished), 32'd0);
    tick();
    bus.core_done = 2'b01;
    tick();
    bus.core_done = 2'b00;
    check("ab_dm0", 32'(bus.done_mask), 32'h1);
    check("ab_fm0", 32'(bus.fail_mask), 32'h1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_crst", 32'(bus.core_reset), 32'h3);
    check("ab_busy", 32'(bus.busy), 32'd0);
    check("ab_fin",  32'(bus.finished), 32'd0);
    check("ab_dm",   32'(bus.done_mask), 32'h0);
    check("ab_fm",   32'(bus.fail_mask), 32'h0);
    tick();
    check("idle_st", 32'(bus.busy), 32'd0);

    // async reset mid-run
    start_run();
    bus.core_done = 2'b01;
    bus.core_ok   = 2'b00;
    repeat (3) tick();
    check("pre_dm", 32'(bus.done_mask), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_crst", 32'(bus.core_reset), 32'h3);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_fin",  32'(bus.finished), 32'd0);
    check("ar_pass", 32'(bus.pass), 32'd0);
    check("ar_to",   32'(bus.timeout), 32'd0);
    check("ar_cnt",  32'(bus.cycle_count), 32'd0);
    check("ar_dm",   32'(bus.done_mask), 32'h0);
    check("ar_fm",   32'(bus.fail_mask), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_run_harness.md
# proc_run_harness

Synthesisable run controller for processor cores, one instance per multi-core test build. It sequences each core's active-high `reset`, then counts run cycles. It collects per-core completion and self-check flags and reports pass, fail or timeout. This generalises the fixed clock/reset/stop stimulus used for the single-cycle processor. Core count, reset hold length and run budget are parameters, and completion is detected per core instead of by fixed time.

## Interface
- `N_CORES`, default 1: number of processor cores controlled (≥1).
- `RESET_CYCLES`, default 2: cycles `core_reset` is held high before release (≥1).
- `TIMEOUT_CYCLES`, default 8: maximum run cycles before timeout (≥1, ≤2^CNT_W).
- `CNT_W`, default 16: width of the run-cycle counter.

- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset of this block.
- `start`, in, 1: begin (or restart) a run; sampled in IDLE and END only.
- `abort`, in, 1: cancel a run in progress; sampled in HOLD and RUN.
- `core_done`, in, N_CORES: per-core completion strobe or level; sampled in RUN only.
- `core_ok`, in, N_CORES: per-core self-check result, valid in the cycle its `core_done` bit is first seen.
- `core_reset`, out, N_CORES: active-high reset to each core; all bits equal.
- `busy`, out, 1: high in HOLD and RUN.
- `finished`, out, 1: high in END.
- `pass`, out, 1: all cores done with `core_ok`=1 (valid when `finished`).
- `timeout`, out, 1: run budget exhausted before all cores were done (valid when `finished`).
- `cycle_count`, out, CNT_W: number of RUN cycles elapsed.
- `done_mask`, out, N_CORES: sticky per-core done flags.
- `fail_mask`, out, N_CORES: sticky per-core failure flags.

## Operation
- All outputs are registered. Reset (`reset`=0, asynchronous) values:
  - state IDLE;
  - `core_reset` all ones;
  - `busy`, `finished`, `pass`, `timeout` = 0;
  - `cycle_count`, `done_mask`, `fail_mask` = 0.
- Four states: IDLE, HOLD, RUN, END.
- IDLE: cores held in reset. `start`=1 moves to HOLD, clears `cycle_count`, masks and status, and loads the hold counter.
- HOLD: `core_reset` stays high for exactly RESET_CYCLES cycles, then the block moves to RUN. `core_done` is ignored.
- RUN: `core_reset`=0.
  - `cycle_count` increments each cycle and saturates at 2^CNT_W−1.
  - For each core i with `core_done[i]`=1 and `done_mask[i]`=0: set `done_mask[i]` and set `fail_mask[i]` = ~`core_ok[i]`.
  - Later `core_done`/`core_ok` changes for core i are ignored.
- Completion: when the updated `done_mask` is all ones, move to END with `finished`=1, `pass` = (updated `fail_mask`==0), `timeout`=0.
- Timeout: if `cycle_count` == TIMEOUT_CYCLES−1 and the updated mask is not all ones, move to END with `finished`=1, `timeout`=1, `pass`=0.
- If completion and timeout occur in the same cycle, completion wins and `timeout`=0.
- END: `core_reset` re-asserted, `busy`=0. Status, masks and `cycle_count` are frozen. `start`=1 restarts at HOLD.
- `abort`=1 in HOLD or RUN returns to IDLE on the next edge, with `core_reset` high and status/masks cleared. `abort` has priority over completion and timeout. `abort` is ignored in IDLE and END.
- `start` is ignored in HOLD and RUN.
- A `reset` assertion mid-run forces the reset values immediately, independent of `clock`.

## Timing
- `start` sampled high at edge T: `busy`=1 from T. `core_reset` stays high through edge T+RESET_CYCLES and falls at edge T+RESET_CYCLES, which is the first RUN cycle.
- `cycle_count` reads 0 in the first RUN cycle and k in the (k+1)th RUN cycle.
- Latency from `core_done` sampled to `finished`=1: one edge.
- Maximum RUN length is exactly TIMEOUT_CYCLES cycles.
- `core_reset` rises on the same edge as `finished`.

## Test plan
Unless stated, `N_CORES`=2, `RESET_CYCLES`=2, `TIMEOUT_CYCLES`=8.
- Reset check: drive `reset`=0 mid-RUN, with no clock edge. Outputs go to reset values immediately and `core_reset`=2'b11.
- Nominal run: `start` pulse, then both `core_done` bits and `core_ok`=2'b11 in RUN cycle 3. Expect `core_reset` high for 2 cycles, `finished`=1, `pass`=1, `timeout`=0, `cycle_count`=3, `done_mask`=2'b11, `fail_mask`=0.
- Staggered done with failure: core0 done with ok=1 at RUN cycle 1, core1 done with ok=0 at cycle 5, core0 done dropping later. Expect `finished` after cycle 5, `pass`=0, `fail_mask`=2'b10.
- Timeout: only core0 done. Expect END after 8 RUN cycles with `timeout`=1, `cycle_count`=7, `done_mask`=2'b01.
- Simultaneous completion and timeout: core1 done in RUN cycle 7 (core0 done earlier), both ok. Expect `timeout`=0, `pass`=1.
- Abort, ignored inputs, restart:
  - `abort` in RUN cycle 2 → IDLE, `core_reset`=2'b11, masks 0.
  - `core_done` held high during HOLD → ignored.
  - `start` in END → new HOLD of 2 cycles, with status cleared.
